// File: rtl/edge_det_multi.sv
// Multi-channel synchronise + debounce edge detector with sticky W1C event flags and irq.
// The masked-edge output is called masked_edge because "edge" is a reserved word.
module edge_det_multi #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] masked_edge,
  output logic [WIDTH-1:0] evt,
  output logic             irq
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] commit;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] evt_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
    end else begin
      sync_q[0] <= sig;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
    end
  end

  // Counter only advances while s disagrees with the committed level; any agreement restarts it.
  always_comb begin
    commit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level[i]) begin
        if (cnt_q[i] == CNT_TC) commit[i] = 1'b1;
        else                    cnt_d[i]  = cnt_q[i] + 1'b1;
      end
    end
    rise_d = commit & s;
    fall_d = commit & ~s;
    edge_d = (rise_d & rise_en) | (fall_d & fall_en);
    evt_d  = edge_d | (evt & ~evt_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      level       <= '0;
      rise        <= '0;
      fall        <= '0;
      masked_edge <= '0;
      evt         <= '0;
      irq         <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      level       <= level ^ commit;
      rise        <= rise_d;
      fall        <= fall_d;
      masked_edge <= edge_d;
      evt         <= evt_d;
      irq         <= |evt_d;
    end
  end

endmodule

// File: tb/tb_edge_det_multi.sv
// Scoreboard bench for edge_det_multi: history-based reference model plus a latency sweep.
module tb_edge_det_multi;
  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 4;
  localparam int SW_S [4] = '{1, 1, 3, 3};
  localparam int SW_D [4] = '{1, 7, 1, 7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] sig, rise_en, fall_en, evt_clr;
  logic [W-1:0] level, rise, fall, medge, evt;
  logic         irq;

  int checks = 0;
  int errors = 0;

  edge_det_multi #(.WIDTH(W), .SYNC_STAGES(S), .DEB_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .sig(sig), .rise_en(rise_en), .fall_en(fall_en),
    .evt_clr(evt_clr), .level(level), .rise(rise), .fall(fall),
    .masked_edge(medge), .evt(evt), .irq(irq)
  );

  logic       sig_p;
  logic [3:0] lv_p, ri_p, fa_p, ed_p, ev_p, irq_p;

  for (genvar g = 0; g < 4; g++) begin : g_sw
    edge_det_multi #(.WIDTH(1), .SYNC_STAGES(SW_S[g]), .DEB_CYCLES(SW_D[g])) u_sw (
      .clk(clk), .rst(rst), .sig(sig_p), .rise_en(1'b1), .fall_en(1'b1),
      .evt_clr(1'b0), .level(lv_p[g]), .rise(ri_p[g]), .fall(fa_p[g]),
      .masked_edge(ed_p[g]), .evt(ev_p[g]), .irq(irq_p[g])
    );
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h exp %0h", nm, $time, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: s is sig delayed S edges; a level flips once the last D samples of s
  // all disagree with it.
  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] edg;
    logic [W-1:0] evt;
    logic         irq;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] pipe[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_level, m_evt, m_s, m_commit, m_rise, m_fall, m_edge;
  exp_t         m_e, mon_e;

  always @(posedge clk) begin
    if (rst) begin
      pipe.delete();
      for (int i = 0; i < S; i++) pipe.push_back('0);
      hist.delete();
      m_level = '0;
      m_evt   = '0;
      m_e     = '0;
    end else begin
      m_s = pipe.pop_front();
      pipe.push_back(sig);
      hist.push_back(m_s);
      if (hist.size() > D) void'(hist.pop_front());
      m_commit = (hist.size() == D) ? '1 : '0;
      foreach (hist[j]) m_commit &= hist[j] ^ m_level;
      m_rise  = m_commit & ~m_level;
      m_fall  = m_commit & m_level;
      m_level = m_level ^ m_commit;
      m_edge  = (m_rise & rise_en) | (m_fall & fall_en);
      m_evt   = m_edge | (m_evt & ~evt_clr);
      m_e.level = m_level;
      m_e.rise  = m_rise;
      m_e.fall  = m_fall;
      m_e.edg   = m_edge;
      m_e.evt   = m_evt;
      m_e.irq   = |m_evt;
    end
    exp_q.push_back(m_e);
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_level", level, mon_e.level);
      chk("sb_rise",  rise,  mon_e.rise);
      chk("sb_fall",  fall,  mon_e.fall);
      chk("sb_edge",  medge, mon_e.edg);
      chk("sb_evt",   evt,   mon_e.evt);
      chk("sb_irq",   irq,   mon_e.irq);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout exp finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat [5];
    int hi_cnt;

    rst = 1'b1; sig = 8'h01; rise_en = 8'hFF; fall_en = '0; evt_clr = '0; sig_p = 1'b0;
    step(3);
    // Input high through reset, plus the single-channel latency sweep.
    rst = 1'b0; sig_p = 1'b1;
    lat = '{-1, -1, -1, -1, -1};
    hi_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (rise[0]) begin
        hi_cnt++;
        if (lat[4] < 0) lat[4] = j;
      end
      for (int g = 0; g < 4; g++)
        if (ri_p[g] && lat[g] < 0) begin
          lat[g] = j;
          chk("sweep_edge_with_rise", ed_p[g], 1);
        end
    end
    chk("reset_high_latency", lat[4], S + D - 1);
    chk("rise0_width", hi_cnt, 1);
    chk("evt0_set", evt[0], 1);
    chk("irq_set", irq, 1);
    for (int g = 0; g < 4; g++) begin
      chk("sweep_latency", lat[g], SW_S[g] + SW_D[g] - 1);
      chk("sweep_level", lv_p[g], 1);
      chk("sweep_evt_irq", {ev_p[g], irq_p[g]}, 3);
      chk("sweep_no_fall", fa_p[g], 0);
    end

    // Glitch rejection then a just-long-enough pulse.
    sig[3] = 1'b1; step(3); sig[3] = 1'b0; step(12);
    chk("glitch_level3", level[3], 0);
    sig[3] = 1'b1; step(4); sig[3] = 1'b0; step(15);
    chk("pulse4_level3_back", level[3], 0);

    // Masking: only the fall on channel 2 counts.
    rise_en = '0; fall_en = 8'h04; evt_clr = 8'hFF; step(1); evt_clr = '0;
    sig[2] = 1'b1; step(12);
    chk("mask_no_evt_on_rise", evt[2], 0);
    sig[2] = 1'b0; step(12);
    chk("mask_evt_on_fall", evt[2], 1);

    // Set/clear collision on channel 5.
    rise_en = 8'h20; fall_en = '0; evt_clr = 8'hFF; step(1); evt_clr = '0;
    sig[5] = 1'b1; step(5);
    evt_clr = 8'h20; step(1);
    chk("collision_evt5", evt[5], 1);
    step(1);
    evt_clr = '0;
    chk("lone_clear_evt5", evt[5], 0);
    chk("lone_clear_irq", irq, 0);

    // Mid-operation reset while channel 1 is part-way through debounce.
    rise_en = 8'hFF; sig[1] = 1'b1; step(4);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("post_reset_outputs", {level, rise, fall, medge, evt, 7'(irq)}, 0);
    lat[0] = -1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (rise[1] && lat[0] < 0) lat[0] = j;
    end
    chk("post_reset_latency", lat[0], S + D - 1);

    // Randomised traffic, occasional resets.
    for (int n = 0; n < 600; n++) begin
      sig = sig ^ W'($urandom & $urandom & $urandom);
      if (n % 32 == 0) begin
        rise_en = W'($urandom);
        fall_en = W'($urandom);
      end
      evt_clr = W'($urandom & $urandom & $urandom);
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0; evt_clr = '0;
    step(10);
    @(negedge clk); #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
